// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction fetch stage.
// Holds the reset PC, the NOP word and the word stride used by the fetch logic.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_STRIDE      = 32'd4;

    // Clear the sub-word offset so the PC always points at a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~(WORD_STRIDE - 32'd1);
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter register: async active-low reset, synchronous load enable.
module pc_register #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else if (load_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing plus the IF/ID pipeline register.
// A branch flushes the wrong-path fetch; freeze holds everything in place.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        pc_load;

    assign pc_plus4 = pc + WORD_STRIDE;

    // Branch wins over freeze, so the PC loads whenever a redirect arrives.
    always_comb begin
        pc_next = pc_plus4;
        pc_load = !freeze;
        if (branch_taken) begin
            pc_next = align_word(branch_addr);
            pc_load = 1'b1;
        end
    end

    pc_register #(
        .RESET_VAL (RESET_PC)
    ) u_pc_register (
        .clk     (clk),
        .rst     (rst),
        .load_en (pc_load),
        .d       (pc_next),
        .q       (pc)
    );

    assign inst_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_out          <= 32'h0000_0000;
            instruction_out <= NOP_INST;
            valid_out       <= 1'b0;
            fetch_count     <= 32'h0000_0000;
        end else if (branch_taken) begin
            pc_out          <= 32'h0000_0000;
            instruction_out <= NOP_INST;
            valid_out       <= 1'b0;
        end else if (!freeze) begin
            pc_out          <= pc_plus4;
            instruction_out <= inst_data;
            valid_out       <= 1'b1;
            fetch_count     <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random
// freeze/branch/reset traffic compared against a cycle-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_pc_out;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [31:0] m_count;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .inst_addr       (inst_addr),
        .inst_data       (inst_data),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: MOV R0,#20 at address 0, a scrambled pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A00014;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign inst_data = mem_word(inst_addr);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        checkOutput({tag, ".inst_addr"}, inst_addr, m_pc);
        checkOutput({tag, ".pc_out"}, pc_out, m_pc_out);
        checkOutput({tag, ".instr"}, instruction_out, m_instr);
        checkOutput({tag, ".valid"}, {31'b0, valid_out}, {31'b0, m_valid});
        checkOutput({tag, ".count"}, fetch_count, m_count);
    endtask

    task automatic model_reset();
        m_pc     = 32'h0;
        m_pc_out = 32'h0;
        m_instr  = NOP;
        m_valid  = 1'b0;
        m_count  = 32'h0;
    endtask

    // One clock edge of the reference behaviour, evaluated from pre-edge state.
    task automatic model_edge(input logic fz, input logic br, input logic [31:0] ba);
        if (br) begin
            m_pc     = {ba[31:2], 2'b00};
            m_pc_out = 32'h0;
            m_instr  = NOP;
            m_valid  = 1'b0;
        end else if (!fz) begin
            m_instr  = mem_word(m_pc);
            m_pc     = m_pc + 32'd4;
            m_pc_out = m_pc;
            m_valid  = 1'b1;
            m_count  = m_count + 32'd1;
        end
    endtask

    task automatic applyStimulus(input logic fz, input logic br, input logic [31:0] ba, input string tag);
        freeze       = fz;
        branch_taken = br;
        branch_addr  = ba;
        @(posedge clk);
        model_edge(fz, br, ba);
        #1;
        check_all(tag);
    endtask

    // Pulse reset low away from any clock edge and check it acts without an edge.
    task automatic pulse_reset(input string tag);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(1'b0, 1'b0, 32'h0, "first_fetch");
        checkOutput("first_fetch.mov", instruction_out, 32'hE3A00014);
        checkOutput("first_fetch.pc4", pc_out, 32'd4);

        applyStimulus(1'b0, 1'b0, 32'h0, "advance");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, "freeze");
        checkOutput("freeze.addr8", inst_addr, 32'd8);
        applyStimulus(1'b0, 1'b0, 32'h0, "unfreeze");
        checkOutput("unfreeze.pc12", pc_out, 32'd12);

        applyStimulus(1'b1, 1'b1, 32'h0000_0093, "branch_freeze");
        checkOutput("branch_freeze.pc90", inst_addr, 32'h90);
        applyStimulus(1'b0, 1'b0, 32'h0, "after_branch");
        checkOutput("after_branch.pc94", pc_out, 32'h94);

        applyStimulus(1'b0, 1'b1, 32'h0000_0010, "b2b_a");
        applyStimulus(1'b0, 1'b1, 32'h0000_0020, "b2b_b");

        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, "branch_top");
        applyStimulus(1'b0, 1'b0, 32'h0, "wrap1");
        checkOutput("wrap1.pc_out0", pc_out, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, "wrap2");
        checkOutput("wrap2.addr4", inst_addr, 32'd4);

        applyStimulus(1'b0, 1'b1, 32'h0000_0040, "branch_40");
        pulse_reset("mid_reset");
        applyStimulus(1'b0, 1'b0, 32'h0, "post_reset");
        checkOutput("post_reset.mov", instruction_out, 32'hE3A00014);

        for (int n = 0; n < 400; n++) begin
            logic        fz;
            logic        br;
            logic [31:0] ba;
            fz = ($urandom_range(0, 2) == 0);
            br = ($urandom_range(0, 4) == 0);
            ba = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            if ($urandom_range(0, 39) == 0) pulse_reset("rand_reset");
            applyStimulus(fz, br, ba, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
